tx_frame_ctrl: RTL
==================

# tx_frame_ctrl

Sequencer for the UART transmit path. Accepts a byte from the host on a write strobe, builds the serial frame (start, 7/8 data bits LSB first, optional parity, 1/2 stop bits), and steps through it one bit per bit-time. It drives DOIT to the bit-time counter and advances on that counter's BTU pulse, producing the TX line and a ready/done handshake back to the host.

## Interface
- No parameters; the frame format is selected at run time by ports.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- write  in  1  load strobe; accepted only while tx_ready=1
- out_port  in  8  data byte; bit 7 ignored when eight=0
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  parity enable
- ohel  in  1  parity sense: 1 = odd, 0 = even
- stop2  in  1  1 = two stop bits, 0 = one stop bit
- btu  in  1  bit-time-up pulse from the bit-time counter
- doit  out  1  run enable to the bit-time counter
- tx  out  1  serial output, idle high
- tx_ready  out  1  1 = idle, write will be accepted
- tx_done  out  1  one-clock pulse at end of frame

## Operation
- Reset values: tx=1, doit=0, tx_ready=1, tx_done=0, state=IDLE, shift register all ones, bit counter 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: on write=1, latch out_port, eight, pen, ohel, stop2; compute parity; go to START. Otherwise btu is ignored.
- START: tx=0. On btu, go to DATA.
- DATA: tx = current data bit, LSB first. Shift on each btu. After 8 bits (eight=1) or 7 bits (eight=0), go to PARITY if pen=1, else go to STOP.
- PARITY: tx = parity bit. On btu, go to STOP.
- STOP: tx=1. On the 1st btu (stop2=0) or the 2nd btu (stop2=1), go to IDLE and pulse tx_done.
- Parity covers only the active data bits. Even parity = XOR of those bits; odd parity = its inverse.
- doit=1 in every state except IDLE.
- write while tx_ready=0 is ignored. The frame in flight is unaffected.
- Format inputs are sampled only at load. Changing them mid-frame has no effect.
- reset asserted mid-frame aborts at once: tx=1, doit=0, tx_ready=1. No tx_done pulse.

## Timing
- Write accepted at edge N: at N+1, tx=0, doit=1, tx_ready=0.
- Each bit lasts from its first cycle through the cycle where btu=1. The next bit appears on the following edge.
- With the counter in the codebase, one bit equals BAUD+1 clocks.
- Frame length = 1 + (7|8) + pen + (1|2) bits.
- Final stop-bit btu at edge M: at M+1, state=IDLE, tx_ready=1, tx_done=1 for exactly one cycle, doit=0.
- Back-to-back: a write during the tx_done cycle is accepted. doit is low for exactly that one cycle, which resets the counter. The new start bit begins at M+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- TX_PARITY_EN defined: parity logic and the PARITY state are built. pen and ohel behave as above.
- TX_PARITY_EN undefined: parity logic is removed, and pen and ohel are ignored. DATA goes directly to STOP. Frame = 1 + (7|8) + (1|2) bits.

## Test plan
All scenarios pair the block with the bit-time counter, BAUD=3 (4 clocks per bit).
- 8N1, write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 at 4 clocks per bit (40 clocks). tx_done pulses once. tx_ready rises with tx_done.
- 7E2, write 0xC3 (eight=0, pen=1, ohel=0, stop2=1) -> data bits 1,1,0,0,0,0,1; parity 1; two stop bits; 44 clocks total.
- 8O1, write 0x00 (ohel=1) -> parity bit 1. Repeat with ohel=0 -> parity bit 0.
- write asserted during DATA with 0xFF -> ignored; the original frame is unchanged. Back-to-back write in the tx_done cycle -> doit low for 1 clock, next start bit one clock later.
- reset pulsed low mid-DATA -> tx=1, doit=0, tx_ready=1 asynchronously, with no tx_done. A subsequent write 0x55 sends a clean frame.
- TX_PARITY_EN undefined, pen=1, 8-bit frame -> no parity bit sent; frame = 10 bits.

Source files
------------

// File: rtl/tx_frame_ctrl.sv
// tx_frame_ctrl: UART transmit frame sequencer; paces bits off the bit-time counter (doit/btu).
// Define TX_PARITY_EN to build the parity bit (pen/ohel, PARITY state); otherwise pen/ohel are ignored.
module tx_frame_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] out_port,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       stop2,
  input  logic       btu,
  output logic       doit,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done
);
  // state  | meaning
  // IDLE   | line high, ready for a write
  // START  | start bit (0)
  // DATA   | data bits, LSB first
  // PARITY | parity bit
  // STOP   | one or two stop bits (1)
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       eight_q;
  logic       stop2_q;
  logic       last_data;

  assign last_data = (bit_cnt == (eight_q ? 3'd7 : 3'd6));

`ifdef TX_PARITY_EN
  logic pen_q;
  logic par_q;
  logic par_calc;
  // bit 7 is excluded from parity in 7-bit mode
  assign par_calc = (^{eight & out_port[7], out_port[6:0]}) ^ ohel;
`else
  logic unused_parity_inputs;
  assign unused_parity_inputs = pen ^ ohel;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= 8'hFF;
      bit_cnt  <= 3'd0;
      eight_q  <= 1'b1;
      stop2_q  <= 1'b0;
      tx       <= 1'b1;
      doit     <= 1'b0;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
`ifdef TX_PARITY_EN
      pen_q    <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (write) begin
            shreg    <= out_port;
            eight_q  <= eight;
            stop2_q  <= stop2;
            bit_cnt  <= 3'd0;
            tx       <= 1'b0;
            doit     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= START;
`ifdef TX_PARITY_EN
            pen_q    <= pen;
            par_q    <= par_calc;
`endif
          end
        end
        START: begin
          if (btu) begin
            tx    <= shreg[0];
            shreg <= {1'b1, shreg[7:1]};
            state <= DATA;
          end
        end
        DATA: begin
          if (btu) begin
            if (last_data) begin
              bit_cnt <= 3'd0;
`ifdef TX_PARITY_EN
              if (pen_q) begin
                tx    <= par_q;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b1, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (btu) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (btu) begin
            if (!stop2_q || bit_cnt[0]) begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              doit     <= 1'b0;
              bit_cnt  <= 3'd0;
            end else begin
              bit_cnt <= 3'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          doit     <= 1'b0;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
